// File: rtl/accel_pkg.sv
// Shared constants for the accelerometer tilt path: sample width,
// tilt encodings and the filter sequencing states.
package accel_pkg;

  localparam int AXIS_W = 16;

  localparam logic [1:0] TILT_NONE  = 2'b00;
  localparam logic [1:0] TILT_LEFT  = 2'b01;
  localparam logic [1:0] TILT_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    UPDATE  = 2'd2
  } state_t;

endpackage

// File: rtl/sample_ring.sv
// Circular history of the last 2**DEPTH_LOG2 samples. The entry at the
// write pointer is the oldest one, i.e. the one about to be overwritten.
module sample_ring
  import accel_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [AXIS_W-1:0] i_wr_data,
  output logic [AXIS_W-1:0] o_oldest
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH-1:0][AXIS_W-1:0] r_ring;
  logic [DEPTH_LOG2-1:0]        r_wr_ptr;

  // Overwrite the oldest entry and advance; pointer wraps by its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ring   <= '0;
      r_wr_ptr <= '0;
    end else if (i_wr_en) begin
      r_ring[r_wr_ptr] <= i_wr_data;
      r_wr_ptr         <= r_wr_ptr + 1'b1;
    end
  end

  assign o_oldest = r_ring[r_wr_ptr];

endmodule

// File: rtl/accel_tilt_filter.sv
// Moving-average filter over accelerometer samples followed by a
// hysteretic left/none/right tilt classifier.
module accel_tilt_filter
  import accel_pkg::*;
#(
  parameter int AVG_LOG2 = 3,
  parameter int TILT_ON  = 16,
  parameter int TILT_OFF = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AXIS_W-1:0] axis_value,
  input  logic              sample_done,
  output logic [AXIS_W-1:0] filt_value,
  output logic              filt_valid,
  output logic [1:0]        tilt,
  output logic              tilt_change,
  output logic              primed
);

  localparam int SUM_W = AXIS_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FILL_FULL = {1'b1, {AVG_LOG2{1'b0}}};

  localparam logic signed [AXIS_W-1:0] P_ON     = AXIS_W'(TILT_ON);
  localparam logic signed [AXIS_W-1:0] P_ON_N   = AXIS_W'(-TILT_ON);
  localparam logic signed [AXIS_W-1:0] P_OFF    = AXIS_W'(TILT_OFF);
  localparam logic signed [AXIS_W-1:0] P_OFF_N  = AXIS_W'(-TILT_OFF);

  state_t r_state, w_state_next;

  logic                     r_sample_done_q;
  logic [AXIS_W-1:0]        r_sample;
  logic signed [SUM_W-1:0]  r_sum;
  logic [AVG_LOG2:0]        r_fill_cnt;
  logic [AXIS_W-1:0]        r_filt_value;
  logic                     r_filt_valid;
  logic [1:0]               r_tilt;
  logic                     r_tilt_change;
  logic                     r_primed;

  logic                     w_rise;
  logic                     w_latch;
  logic                     w_capture;
  logic                     w_update;
  logic [AXIS_W-1:0]        w_oldest;
  logic signed [SUM_W-1:0]  w_sample_ext;
  logic signed [SUM_W-1:0]  w_oldest_ext;
  logic signed [AXIS_W-1:0] w_avg;
  logic [1:0]               w_tilt_next;

  assign w_rise = sample_done & ~r_sample_done_q;

  // Delayed copy of the strobe for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sample_done_q <= 1'b0;
    else        r_sample_done_q <= sample_done;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: edges arriving outside IDLE are dropped, not queued.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_state_next = CAPTURE;
      CAPTURE: w_state_next = UPDATE;
      UPDATE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: one enable per datapath phase.
  always_comb begin
    w_latch   = 1'b0;
    w_capture = 1'b0;
    w_update  = 1'b0;
    case (r_state)
      IDLE:    w_latch   = w_rise;
      CAPTURE: w_capture = 1'b1;
      UPDATE:  w_update  = 1'b1;
      default: ;
    endcase
  end

  sample_ring #(
    .DEPTH_LOG2(AVG_LOG2)
  ) u_ring (
    .clk      (clk),
    .rst_n    (reset),
    .i_wr_en  (w_capture),
    .i_wr_data(r_sample),
    .o_oldest (w_oldest)
  );

  assign w_sample_ext = {{AVG_LOG2{r_sample[AXIS_W-1]}}, r_sample};
  assign w_oldest_ext = {{AVG_LOG2{w_oldest[AXIS_W-1]}}, w_oldest};

  // Dropping the low AVG_LOG2 bits of a two's complement sum is the
  // arithmetic shift (floor toward -inf); the remaining width always fits.
  assign w_avg = r_sum[SUM_W-1:AVG_LOG2];

  // Hold the sample stable while the running sum is updated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_sample <= '0;
    else if (w_latch) r_sample <= axis_value;
  end

  // Running window sum: add the newcomer, retire the oldest entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum      <= '0;
      r_fill_cnt <= '0;
    end else if (w_capture) begin
      r_sum <= r_sum + w_sample_ext - w_oldest_ext;
      if (r_fill_cnt != FILL_FULL) r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  // Tilt hysteresis: a full reversal wins over a release.
  always_comb begin
    w_tilt_next = r_tilt;
    case (r_tilt)
      TILT_RIGHT: begin
        if (w_avg <= P_ON_N)     w_tilt_next = TILT_LEFT;
        else if (w_avg < P_OFF)  w_tilt_next = TILT_NONE;
      end
      TILT_LEFT: begin
        if (w_avg >= P_ON)        w_tilt_next = TILT_RIGHT;
        else if (w_avg > P_OFF_N) w_tilt_next = TILT_NONE;
      end
      default: begin
        if (w_avg >= P_ON)        w_tilt_next = TILT_RIGHT;
        else if (w_avg <= P_ON_N) w_tilt_next = TILT_LEFT;
        else                      w_tilt_next = TILT_NONE;
      end
    endcase
  end

  // Publish the average; classify and pulse only once the window is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt_value  <= '0;
      r_filt_valid  <= 1'b0;
      r_tilt        <= TILT_NONE;
      r_tilt_change <= 1'b0;
      r_primed      <= 1'b0;
    end else begin
      r_filt_valid  <= 1'b0;
      r_tilt_change <= 1'b0;
      if (w_update) begin
        r_filt_value <= w_avg;
        if (r_fill_cnt == FILL_FULL) begin
          r_primed      <= 1'b1;
          r_filt_valid  <= 1'b1;
          r_tilt        <= w_tilt_next;
          r_tilt_change <= (w_tilt_next != r_tilt);
        end
      end
    end
  end

  assign filt_value  = r_filt_value;
  assign filt_valid  = r_filt_valid;
  assign tilt        = r_tilt;
  assign tilt_change = r_tilt_change;
  assign primed      = r_primed;

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Directed bench for accel_tilt_filter with hand-computed expectations.
module tb_accel_tilt_filter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] axis_value = '0;
  logic        sample_done = 1'b0;
  logic [15:0] filt_value;
  logic        filt_valid;
  logic [1:0]  tilt;
  logic        tilt_change;
  logic        primed;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt  = 0;

  accel_tilt_filter dut (
    .clk        (clk),
    .reset      (reset),
    .axis_value (axis_value),
    .sample_done(sample_done),
    .filt_value (filt_value),
    .filt_valid (filt_valid),
    .tilt       (tilt),
    .tilt_change(tilt_change),
    .primed     (primed)
  );

  always #5 clk = ~clk;

  // Count filt_valid pulses away from the active edge.
  always @(negedge clk) if (filt_valid) vcnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One strobe; returns outputs just after edge N+2 (rise seen at edge N).
  task automatic strobe(input logic [15:0] v, output logic fv, output logic [15:0] fval,
                        output logic [1:0] t, output logic tc, output logic pr);
    @(negedge clk);
    axis_value  = v;
    sample_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_done = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    fv = filt_valid; fval = filt_value; t = tilt; tc = tilt_change; pr = primed;
    @(posedge clk);
  endtask

  logic        fv, tc, pr;
  logic [15:0] fval;
  logic [1:0]  t;
  int          v0;
  int          exp_avg [5] = '{17, 15, 12, 10, 7};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with strobes toggling underneath it.
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); sample_done = 1'b1; axis_value = 16'd99;
      @(negedge clk); sample_done = 1'b0;
    end
    #1;
    chk("rst_filt_value", filt_value, 0);
    chk("rst_tilt", tilt, 0);
    chk("rst_primed", primed, 0);
    chk("rst_flags", {filt_valid, tilt_change}, 0);
    chk("rst_no_valid", vcnt, 0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);

    // Eight samples of 20.
    for (int i = 0; i < 7; i++) strobe(16'd20, fv, fval, t, tc, pr);
    chk("fill_no_valid", vcnt, 0);
    chk("fill_not_primed", primed, 0);
    strobe(16'd20, fv, fval, t, tc, pr);
    chk("p8_valid", fv, 1);
    chk("p8_value", fval, 20);
    chk("p8_primed", pr, 1);
    chk("p8_tilt", t, 2);
    chk("p8_change", tc, 1);

    // Decay with zeros: right holds until the average drops below 8.
    for (int i = 0; i < 5; i++) begin
      strobe(16'd0, fv, fval, t, tc, pr);
      chk("decay_value", fval, exp_avg[i]);
      chk("decay_tilt", t, (i == 4) ? 0 : 2);
      chk("decay_change", tc, (i == 4) ? 1 : 0);
    end

    // Flush to all zeros, then seven zeros and a -1: floors to -1.
    for (int i = 0; i < 10; i++) strobe(16'd0, fv, fval, t, tc, pr);
    chk("zero_value", fval, 0);
    strobe(16'hFFFF, fv, fval, t, tc, pr);
    chk("round_value", fval, 16'hFFFF);
    chk("round_tilt", t, 0);
    chk("round_change", tc, 0);

    // Level held high 50 cycles yields one sample.
    v0 = vcnt;
    @(negedge clk); axis_value = 16'd0; sample_done = 1'b1;
    repeat (50) @(negedge clk);
    sample_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_one_valid", vcnt - v0, 1);

    // Low pulse then high while the FSM is busy: edge is dropped.
    v0 = vcnt;
    @(negedge clk); sample_done = 1'b1;
    @(negedge clk); sample_done = 1'b0;
    @(negedge clk); sample_done = 1'b1;
    repeat (3) @(negedge clk);
    sample_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_drop", vcnt - v0, 1);

    // Reset after five samples of -40.
    for (int i = 0; i < 5; i++) strobe(16'hFFD8, fv, fval, t, tc, pr);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("mid_rst_value", filt_value, 0);
    chk("mid_rst_primed", primed, 0);
    @(negedge clk); reset = 1'b1;
    v0 = vcnt;
    for (int i = 0; i < 7; i++) begin
      strobe(16'hFFD8, fv, fval, t, tc, pr);
      chk("post_rst_primed", pr, 0);
    end
    chk("post_rst_no_valid", vcnt - v0, 0);
    strobe(16'hFFD8, fv, fval, t, tc, pr);
    chk("neg_valid", fv, 1);
    chk("neg_value", fval, 16'hFFD8);
    chk("neg_primed", pr, 1);
    chk("neg_tilt", t, 1);
    chk("neg_change", tc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
